// File: rtl/instr_load_mem_pkg.sv
// Shared constants for the instruction-load memory: default sizes, NOP encoding, FSM states.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package instr_load_mem_pkg;

    localparam int DEPTH_DEF  = 64;
    localparam int ADDR_W_DEF = 6;
    localparam int DATA_W_DEF = 32;

    // Instruction returned for any fetch that does not hit a loaded program word.
    localparam logic [31:0] NOP = 32'h0000_0000;

    // Controller states. IDLE means no program is held, READY means one is.
    localparam logic [1:0] ST_IDLE    = 2'b00;
    localparam logic [1:0] ST_LOADING = 2'b01;
    localparam logic [1:0] ST_READY   = 2'b10;

endpackage

// File: rtl/instr_load_mem_if.sv
// Load/fetch bus between the CPU front end (master) and the instruction memory (slave).
// Latency: n/a (wiring only).
// Backpressure: none; loads are accepted every cycle, fetch_en=0 stalls the fetch outputs.
//
// Signals:
//   LoadInstructions  master->slave  1 = capture Instruction this cycle
//   Instruction       master->slave  word to store
//   fetch_en          master->slave  fetch request, 0 holds the fetch outputs
//   PC                master->slave  byte address of the fetch
//   instr_out         slave->master  fetched word (NOP when invalid)
//   instr_valid       slave->master  instr_out is a real program word
//   prog_len          slave->master  words in the loaded program
//   load_done         slave->master  one-cycle pulse when a load window closes
//   overflow          slave->master  sticky, a word was offered to a full memory
interface instr_load_mem_if #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 32
);
    logic              LoadInstructions;
    logic [DATA_W-1:0] Instruction;
    logic              fetch_en;
    logic [31:0]       PC;
    logic [DATA_W-1:0] instr_out;
    logic              instr_valid;
    logic [ADDR_W:0]   prog_len;
    logic              load_done;
    logic              overflow;

    modport master (
        output LoadInstructions, Instruction, fetch_en, PC,
        input  instr_out, instr_valid, prog_len, load_done, overflow
    );

    modport slave (
        input  LoadInstructions, Instruction, fetch_en, PC,
        output instr_out, instr_valid, prog_len, load_done, overflow
    );
endinterface

// File: rtl/instr_ram.sv
// Instruction storage: one write port, one synchronous read port, no reset (block-RAM friendly).
// Latency: read data appears one clk after i_rd_en; write lands on the same edge.
// Backpressure: none; o_rd_dat holds its value while i_rd_en is low.
//
// Ports: clk; i_wr_en/i_wr_addr/i_wr_dat write port; i_rd_en/i_rd_addr read request;
//        o_rd_dat registered read data (old contents on a same-address read/write).
module instr_ram #(
    parameter int DEPTH  = 64,
    parameter int ADDR_W = 6,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              i_wr_en,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [DATA_W-1:0] i_wr_dat,
    input  logic              i_rd_en,
    input  logic [ADDR_W-1:0] i_rd_addr,
    output logic [DATA_W-1:0] o_rd_dat
);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_rd_dat;

    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_dat;
        end
        if (i_rd_en) begin
            r_rd_dat <= r_mem[i_rd_addr];
        end
    end

    assign o_rd_dat = r_rd_dat;

endmodule

// File: rtl/instr_load_mem.sv
// Instruction memory: captures a program word per cycle during a load window, then serves PC fetches.
// Latency: fetch result one clk after the request edge; load_done one clk after the window closes.
// Backpressure: none on loads (words beyond DEPTH are dropped and flagged); fetch_en=0 holds outputs.
//
// Ports: clk; Reset (async, active low); bus = instr_load_mem_if.slave (load, fetch and status).
module instr_load_mem
    import instr_load_mem_pkg::*;
#(
    parameter int DEPTH  = DEPTH_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              Reset,
    instr_load_mem_if.slave   bus
);

    logic              r_loading;
    logic [ADDR_W:0]   r_wr_ptr;
    logic              r_instr_valid;
    logic              r_load_done;
    logic              r_overflow;
    // Survives Reset so the CPU restarts on the same program; zero only at power-up.
    logic [ADDR_W:0]   r_prog_len = '0;

    logic [1:0]        w_state;
    logic [ADDR_W-1:0] w_idx;
    logic              w_full;
    logic              w_wr_en;
    logic [ADDR_W-1:0] w_wr_addr;
    logic              w_rd_en;
    logic [DATA_W-1:0] w_rd_dat;
    logic              w_unused_pc;

    // IDLE and READY differ only in whether a program is held, so the state is
    // derived from the loading flag and prog_len. This also gives the right state
    // straight out of reset without a data-dependent reset value.
    always_comb begin
        w_state = ST_IDLE;
        if (r_loading) begin
            w_state = ST_LOADING;
        end else if (r_prog_len != '0) begin
            w_state = ST_READY;
        end
    end

    // Word index wraps modulo DEPTH; byte-offset and high PC bits are ignored.
    assign w_idx       = bus.PC[ADDR_W+1:2];
    assign w_unused_pc = ^{bus.PC[31:ADDR_W+2], bus.PC[1:0]};

    // Pointer reaching DEPTH sets its top bit: no wrap, further words are dropped.
    assign w_full = r_wr_ptr[ADDR_W];

    // Opening a window always writes slot 0, whatever the stale pointer holds.
    assign w_wr_en   = bus.LoadInstructions && (!r_loading || !w_full);
    assign w_wr_addr = r_loading ? r_wr_ptr[ADDR_W-1:0] : '0;

    // The RAM is read only for honoured fetches, so its output register doubles
    // as the hold register while fetch_en is low.
    assign w_rd_en = (w_state == ST_READY) && bus.fetch_en;

    instr_ram #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_ram (
        .clk       (clk),
        .i_wr_en   (w_wr_en),
        .i_wr_addr (w_wr_addr),
        .i_wr_dat  (bus.Instruction),
        .i_rd_en   (w_rd_en),
        .i_rd_addr (w_idx),
        .o_rd_dat  (w_rd_dat)
    );

    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            r_loading     <= 1'b0;
            r_wr_ptr      <= '0;
            r_instr_valid <= 1'b0;
            r_load_done   <= 1'b0;
            r_overflow    <= 1'b0;
        end else begin
            r_load_done <= 1'b0;

            case (w_state)
                ST_LOADING: begin
                    if (bus.LoadInstructions) begin
                        if (!w_full) begin
                            r_wr_ptr <= r_wr_ptr + (ADDR_W+1)'(1);
                        end else begin
                            r_overflow <= 1'b1;
                        end
                    end else begin
                        r_loading   <= 1'b0;
                        r_load_done <= 1'b1;
                    end
                end
                default: begin
                    if (bus.LoadInstructions) begin
                        r_loading  <= 1'b1;
                        r_wr_ptr   <= (ADDR_W+1)'(1);
                        r_overflow <= 1'b0;
                    end
                end
            endcase

            // Fetch is judged on the state before this edge, so the closing edge of a
            // load window still yields NOP.
            if (w_state == ST_READY) begin
                if (bus.fetch_en) begin
                    r_instr_valid <= ({1'b0, w_idx} < r_prog_len);
                end
            end else begin
                r_instr_valid <= 1'b0;
            end
        end
    end

    // No reset here: program length must outlive Reset. Reset forces r_loading low,
    // so this cannot fire while Reset is asserted.
    always_ff @(posedge clk) begin
        if ((w_state == ST_LOADING) && !bus.LoadInstructions) begin
            r_prog_len <= r_wr_ptr;
        end
    end

    assign bus.instr_out   = r_instr_valid ? w_rd_dat : DATA_W'(NOP);
    assign bus.instr_valid = r_instr_valid;
    assign bus.prog_len    = r_prog_len;
    assign bus.load_done   = r_load_done;
    assign bus.overflow    = r_overflow;

endmodule

// File: tb/tb_instr_load_mem.sv
// Bench for instr_load_mem: directed scenarios plus randomized load/fetch traffic.
// Latency: checks outputs on the falling edge after each rising edge.
// Backpressure: n/a.
module tb_instr_load_mem;
    import instr_load_mem_pkg::*;

    logic clk = 1'b0;
    logic Reset;
    always #5 clk = ~clk;

    instr_load_mem_if #(.ADDR_W(6), .DATA_W(32)) bus();

    instr_load_mem #(.DEPTH(64), .ADDR_W(6), .DATA_W(32)) dut (
        .clk   (clk),
        .Reset (Reset),
        .bus   (bus.slave)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model: program-level view of the memory.
    logic [31:0] m_mem [64];
    bit          m_loading  = 1'b0;
    int          m_cnt      = 0;   // words accepted in the current window
    int          m_prog_len = 0;
    bit          m_ovf      = 1'b0;
    bit          m_done     = 1'b0;
    logic [31:0] m_out      = 32'h0;
    bit          m_vld      = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("instr_out",   bus.instr_out,          m_out);
        chk("instr_valid", 32'(bus.instr_valid),   32'(m_vld));
        chk("prog_len",    32'(bus.prog_len),      32'(m_prog_len));
        chk("load_done",   32'(bus.load_done),     32'(m_done));
        chk("overflow",    32'(bus.overflow),      32'(m_ovf));
    endtask

    // One clock: inputs applied now (falling edge), model advanced at the rising
    // edge, outputs compared at the next falling edge.
    task automatic step(input bit ld, input logic [31:0] w, input bit fen, input logic [31:0] pc);
        int idx;
        bit ready;
        bus.LoadInstructions = ld;
        bus.Instruction      = w;
        bus.fetch_en         = fen;
        bus.PC               = pc;
        @(posedge clk);
        ready = !m_loading && (m_prog_len != 0);
        // Fetch sees memory contents from before this edge's write.
        if (!ready) begin
            m_out = 32'h0;
            m_vld = 1'b0;
        end else if (fen) begin
            idx = int'(pc[7:2]);
            if (idx < m_prog_len) begin
                m_out = m_mem[idx];
                m_vld = 1'b1;
            end else begin
                m_out = 32'h0;
                m_vld = 1'b0;
            end
        end
        m_done = m_loading && !ld;
        if (ld) begin
            if (!m_loading) begin
                m_loading = 1'b1;
                m_cnt     = 0;
                m_ovf     = 1'b0;
            end
            if (m_cnt < 64) begin
                m_mem[m_cnt] = w;
                m_cnt++;
            end else begin
                m_ovf = 1'b1;
            end
        end else if (m_loading) begin
            m_loading  = 1'b0;
            m_prog_len = m_cnt;
        end
        @(negedge clk);
        check_all();
    endtask

    // Reset asserted across one rising edge; outputs checked while still in reset.
    task automatic do_reset();
        bus.LoadInstructions = 1'b0;
        bus.fetch_en         = 1'b0;
        Reset = 1'b0;
        m_loading = 1'b0;
        m_out     = 32'h0;
        m_vld     = 1'b0;
        m_done    = 1'b0;
        m_ovf     = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_all();
        Reset = 1'b1;
    endtask

    task automatic load_words(input int n, input logic [31:0] base);
        for (int k = 0; k < n; k++) begin
            step(1'b1, base + 32'(k) * 32'h0001_0000, 1'b0, 32'h0);
        end
    endtask

    logic [31:0] first_word;
    logic [31:0] held;
    int          win_left;

    initial begin
        bus.LoadInstructions = 1'b0;
        bus.Instruction      = 32'h0;
        bus.fetch_en         = 1'b0;
        bus.PC               = 32'h0;
        Reset                = 1'b1;
        @(negedge clk);

        // 1: reset, empty memory.
        do_reset();
        step(1'b0, 32'h0, 1'b1, 32'h0);
        chk("t1_out", bus.instr_out, 32'h0);
        chk("t1_prog_len", 32'(bus.prog_len), 32'd0);

        // 2: five addi words; 5th word is 0x20050001.
        load_words(5, 32'h2001_0001);
        step(1'b0, 32'h0, 1'b1, 32'h10);
        chk("t2_close_nop", 32'(bus.instr_valid), 32'd0);
        chk("t2_done", 32'(bus.load_done), 32'd1);
        chk("t2_prog_len", 32'(bus.prog_len), 32'd5);
        step(1'b0, 32'h0, 1'b1, 32'h10);
        chk("t2_word5", bus.instr_out, 32'h2005_0001);
        chk("t2_done_gone", 32'(bus.load_done), 32'd0);

        // 3: out-of-program fetch and index wrap.
        step(1'b0, 32'h0, 1'b1, 32'h14);
        chk("t3_oob_valid", 32'(bus.instr_valid), 32'd0);
        step(1'b0, 32'h0, 1'b1, 32'h100);
        chk("t3_wrap", bus.instr_out, 32'h2001_0001);

        // 4: 66-word overflow; a new load clears the flag.
        first_word = $urandom;
        step(1'b1, first_word, 1'b0, 32'h0);
        for (int k = 1; k < 66; k++) step(1'b1, $urandom, 1'b0, 32'h0);
        step(1'b0, 32'h0, 1'b0, 32'h0);
        chk("t4_prog_len", 32'(bus.prog_len), 32'd64);
        chk("t4_overflow", 32'(bus.overflow), 32'd1);
        step(1'b0, 32'h0, 1'b1, 32'h0);
        chk("t4_mem0_kept", bus.instr_out, first_word);
        step(1'b0, 32'h0, 1'b1, 32'hFC);
        step(1'b1, 32'hDEAD_0001, 1'b0, 32'h0);
        chk("t4_ovf_clear", 32'(bus.overflow), 32'd0);
        step(1'b0, 32'h0, 1'b0, 32'h0);

        // 5: program survives reset.
        load_words(3, 32'h1000_0007);
        step(1'b0, 32'h0, 1'b0, 32'h0);
        do_reset();
        step(1'b0, 32'h0, 1'b1, 32'h0);
        chk("t5_w0", bus.instr_out, 32'h1000_0007);
        step(1'b0, 32'h0, 1'b1, 32'h4);
        chk("t5_w1", bus.instr_out, 32'h1001_0007);
        step(1'b0, 32'h0, 1'b1, 32'h8);
        chk("t5_w2", bus.instr_out, 32'h1002_0007);
        chk("t5_prog_len", 32'(bus.prog_len), 32'd3);

        // 6: stall holds outputs; reset mid-load keeps old length.
        step(1'b0, 32'h0, 1'b1, 32'h4);
        held = bus.instr_out;
        for (int k = 0; k < 3; k++) begin
            step(1'b0, 32'h0, 1'b0, 32'(k * 4 + 8));
            chk("t6_hold", bus.instr_out, 32'h1001_0007);
        end
        chk("t6_held_same", bus.instr_out, held);
        load_words(2, 32'h3000_0000);
        do_reset();
        chk("t6_prog_len", 32'(bus.prog_len), 32'd3);
        step(1'b0, 32'h0, 1'b1, 32'h0);

        // Random traffic.
        win_left = 0;
        for (int c = 0; c < 3000; c++) begin
            bit ld;
            logic [31:0] pc;
            if ($urandom_range(0, 499) == 0) begin
                do_reset();
                win_left = 0;
            end
            ld = 1'b0;
            if (win_left > 0) begin
                ld = 1'b1;
                win_left--;
            end else if ($urandom_range(0, 14) == 0) begin
                win_left = $urandom_range(1, 70);
            end
            pc = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 255));
            step(ld, $urandom, $urandom_range(0, 3) != 0, pc);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
